// File: rtl/dial_pkg.sv
// Shared types for the dial command engine and its reusable wrap/apply helper.
package dial_pkg;

    typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dial_dir_e;

    typedef enum {IDLE, REDUCE} dial_state_e;

endpackage

// File: rtl/dial_wrap_apply.sv
// Applies a sub-revolution turn (rem < DIAL_SIZE) to a dial position; flags a click landing on 0.
// Purely combinational: zero latency, no flow control.
module dial_wrap_apply
    import dial_pkg::*;
#(
    parameter int DIAL_SIZE = 100,
    localparam int POS_W = $clog2(DIAL_SIZE)
) (
    input  logic [POS_W-1:0] pos,
    input  logic [POS_W-1:0] rem,
    input  logic             dir,
    output logic [POS_W-1:0] new_pos,
    output logic             hit
);

    localparam logic [POS_W:0] DS = (POS_W+1)'(DIAL_SIZE);

    logic [POS_W:0] pos_x;
    logic [POS_W:0] rem_x;
    logic [POS_W:0] sum;

    always_comb begin
        pos_x   = {1'b0, pos};
        rem_x   = {1'b0, rem};
        sum     = pos_x + rem_x;
        hit     = 1'b0;
        new_pos = pos;
        if (dir == DIR_RIGHT) begin
            hit     = (sum >= DS);
            new_pos = POS_W'(hit ? sum - DS : sum);
        end else begin
            // Leaving 0 is not a hit; only arriving on 0 (or passing through it) counts.
            hit     = (rem != '0) && (pos != '0) && (rem >= pos);
            new_pos = POS_W'((rem > pos) ? pos_x + DS - rem_x : pos_x - rem_x);
        end
    end

endmodule

// File: rtl/dial_cmd_engine.sv
// Applies rotation commands to a modulo-DIAL_SIZE dial, one whole revolution per cycle then the partial turn.
// Latency floor(D/DIAL_SIZE)+1 edges after accept, done pulses next cycle; cmd_ready low while a command is in flight.
module dial_cmd_engine
    import dial_pkg::*;
#(
    parameter int DIAL_SIZE = 100,
    parameter int START_POS = 50,
    parameter int DIST_W    = 16,
    parameter int CNT_W     = 32,
    localparam int POS_W    = $clog2(DIAL_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [DIST_W-1:0] cmd_dist,
    output logic [POS_W-1:0]  dial_pos,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  land_count,
    output logic              cnt_sat,
    output logic              done,
    output logic              busy
);

    if (DIAL_SIZE < 2 || START_POS < 0 || START_POS >= DIAL_SIZE || DIST_W < 1 || CNT_W < 1) begin : g_param_chk
        $error("dial_cmd_engine: illegal parameter combination");
    end

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_REDUCE = 1'b1;
    localparam int   RW        = (DIST_W > POS_W + 1) ? DIST_W : POS_W + 1;
    localparam logic [RW-1:0]    DS_R  = RW'(DIAL_SIZE);
    localparam logic [POS_W-1:0] START = POS_W'(START_POS);

    logic              state;
    logic              dir_q;
    logic [DIST_W-1:0] rem_q;
    logic [RW-1:0]     rem_x;
    logic              full_rev;
    logic [POS_W-1:0]  apply_pos;
    logic              apply_hit;
    logic              pass_inc;
    logic              land_inc;

    assign busy      = (state == ST_REDUCE);
    assign cmd_ready = !busy;
    assign rem_x     = RW'(rem_q);
    assign full_rev  = (rem_x >= DS_R);
    assign pass_inc  = busy && (full_rev || apply_hit);
    assign land_inc  = busy && !full_rev && (apply_pos == '0);

    dial_wrap_apply #(
        .DIAL_SIZE (DIAL_SIZE)
    ) u_apply (
        .pos     (dial_pos),
        .rem     (POS_W'(rem_q)),
        .dir     (dir_q),
        .new_pos (apply_pos),
        .hit     (apply_hit)
    );

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= ST_IDLE;
            dir_q      <= DIR_LEFT;
            rem_q      <= '0;
            dial_pos   <= START;
            pass_count <= '0;
            land_count <= '0;
            cnt_sat    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        dir_q <= cmd_dir;
                        rem_q <= cmd_dist;
                        state <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    if (full_rev) begin
                        rem_q <= DIST_W'(rem_x - DS_R);
                    end else begin
                        dial_pos <= apply_pos;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Counters stick at all-ones; a blocked increment latches cnt_sat.
            if (pass_inc) begin
                if (&pass_count) cnt_sat <= 1'b1;
                else             pass_count <= pass_count + 1'b1;
            end
            if (land_inc) begin
                if (&land_count) cnt_sat <= 1'b1;
                else             land_count <= land_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dial_cmd_engine.sv
// Directed-vector bench for dial_cmd_engine with a done-triggered scoreboard monitor.
module tb_dial_cmd_engine;

    localparam int DIAL_SIZE = 100;
    localparam int START_POS = 50;
    localparam int DIST_W    = 16;
    localparam int CNT_W     = 4;
    localparam int POS_W     = $clog2(DIAL_SIZE);

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [DIST_W-1:0] cmd_dist;
    logic [POS_W-1:0]  dial_pos;
    logic [CNT_W-1:0]  pass_count;
    logic [CNT_W-1:0]  land_count;
    logic              cnt_sat;
    logic              done;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string name;
        int    pos;
        int    pass;
        int    land;
        int    sat;
    } exp_t;

    exp_t exp_q[$];

    dial_cmd_engine #(
        .DIAL_SIZE (DIAL_SIZE),
        .START_POS (START_POS),
        .DIST_W    (DIST_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_dist   (cmd_dist),
        .dial_pos   (dial_pos),
        .pass_count (pass_count),
        .land_count (land_count),
        .cnt_sat    (cnt_sat),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 with no command outstanding, expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_pos"},  32'(dial_pos),   e.pos);
                check({e.name, "_pass"}, 32'(pass_count), e.pass);
                check({e.name, "_land"}, 32'(land_count), e.land);
                check({e.name, "_sat"},  32'(cnt_sat),    e.sat);
            end
        end
    end

    task automatic send(input string nm, input bit d, input int n, input int ep, input int epass,
                        input int eland, input int esat, input bit push, output bit done_at_acc);
        int t = 0;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_dist  = 16'(n);
        if (push) begin
            e.name = nm; e.pos = ep; e.pass = epass; e.land = eland; e.sat = esat;
            exp_q.push_back(e);
        end
        while (cmd_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check({nm, "_accept_timeout"}, 32'(cmd_ready), 1);
        done_at_acc = (done === 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        @(negedge clk);
        while ((cmd_ready !== 1'b1 || done === 1'b1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check({nm, "_idle_timeout"}, 32'(cmd_ready), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit dacc;
        int b;
        reset     = 1'b1;
        clear     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_dist  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_pos",   32'(dial_pos),   50);
        check("rst_pass",  32'(pass_count), 0);
        check("rst_land",  32'(land_count), 0);
        check("rst_sat",   32'(cnt_sat),    0);
        check("rst_ready", 32'(cmd_ready),  1);
        check("rst_busy",  32'(busy),       0);
        check("rst_done",  32'(done),       0);

        // R50 from 50 lands exactly on 0; done one cycle after the apply edge.
        send("t1_r50", 1'b1, 50, 0, 1, 1, 0, 1'b1, dacc);
        @(negedge clk);
        check("t1_done_early", 32'(done), 0);
        check("t1_busy",       32'(busy), 1);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 1);
        wait_idle("t1");

        do_reset();
        send("t2_l68", 1'b0, 68, 82, 1, 0, 0, 1'b1, dacc);
        wait_idle("t2a");
        send("t2_l30", 1'b0, 30, 52, 1, 0, 0, 1'b1, dacc);
        wait_idle("t2b");

        do_reset();
        send("t3_l1000", 1'b0, 1000, 50, 10, 0, 0, 1'b1, dacc);
        b = 0;
        @(negedge clk);
        while (busy === 1'b1 && b < 50) begin
            b++;
            @(negedge clk);
        end
        check("t3_busy_cycles", 32'(b), 11);
        wait_idle("t3");

        do_reset();
        send("t4_r50", 1'b1, 50, 0, 1, 1, 0, 1'b1, dacc);
        wait_idle("t4a");
        send("t4_l5", 1'b0, 5, 95, 1, 1, 0, 1'b1, dacc);
        wait_idle("t4b");
        send("t4_r5", 1'b1, 5, 0, 2, 2, 0, 1'b1, dacc);
        wait_idle("t4c");

        // Back-to-back: valid held, second command accepted in the done cycle of the first.
        do_reset();
        send("t5_r0", 1'b1, 0, 50, 0, 0, 0, 1'b1, dacc);
        cmd_valid = 1'b1;
        cmd_dist  = 16'd1;
        @(negedge clk);
        check("t5_ready_low", 32'(cmd_ready), 0);
        check("t5_busy_high", 32'(busy),      1);
        send("t5_r1", 1'b1, 1, 51, 0, 0, 0, 1'b1, dacc);
        check("t5_accept_in_done", 32'(dacc), 1);
        wait_idle("t5");

        do_reset();
        send("t6_l1000_rst", 1'b0, 1000, 0, 0, 0, 0, 1'b0, dacc);
        repeat (3) @(negedge clk);
        check("t6_pass_mid", 32'(pass_count), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6r_pos",   32'(dial_pos),   50);
        check("t6r_pass",  32'(pass_count), 0);
        check("t6r_ready", 32'(cmd_ready),  1);
        check("t6r_done",  32'(done),       0);
        @(negedge clk);
        check("t6r_no_done", 32'(done), 0);

        send("t6_r25", 1'b1, 25, 75, 0, 0, 0, 1'b1, dacc);
        wait_idle("t6c");
        send("t6_l1000_clr", 1'b0, 1000, 0, 0, 0, 0, 1'b0, dacc);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t6c_pos",   32'(dial_pos),   50);
        check("t6c_pass",  32'(pass_count), 0);
        check("t6c_land",  32'(land_count), 0);
        check("t6c_ready", 32'(cmd_ready),  1);
        check("t6c_done",  32'(done),       0);
        @(negedge clk);
        check("t6c_no_done", 32'(done), 0);

        // 4-bit counters: drive pass_count to all-ones and past it.
        send("t7_l1000", 1'b0, 1000, 50, 10, 0, 0, 1'b1, dacc);
        wait_idle("t7a");
        send("t7_r50", 1'b1, 50, 0, 11, 1, 0, 1'b1, dacc);
        wait_idle("t7b");
        send("t7_l1000_sat", 1'b0, 1000, 0, 15, 2, 1, 1'b1, dacc);
        wait_idle("t7c");
        send("t7_r100", 1'b1, 100, 0, 15, 3, 1, 1'b1, dacc);
        wait_idle("t7d");

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
